// File: rtl/punt_responder.sv
// punt_responder: target-side responder for punted RTC/JOY/BTN CPU cycles.
// Serves a 12-byte register file onto D[31:24] and exchanges data with the MCU over SPI.
module punt_responder #(
    parameter int SETUP     = 2,
    parameter int ACK_WIDTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic       CLKCPU_A,
    input  logic       RESET,
    input  logic       REQ_RTC,
    input  logic       REQ_BTN,
    input  logic       REQ_JOY,
    input  logic [1:0] SEL,
    input  logic       RW,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       ACK,
    input  logic       SPI_NSS,
    input  logic       SPI_CK,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO
);

    localparam int         NREG         = 12;
    localparam logic [1:0] TYPE_RTC     = 2'd0;
    localparam logic [1:0] TYPE_JOY     = 2'd1;
    localparam logic [1:0] TYPE_BTN     = 2'd2;
    localparam logic [7:0] SETUP_LAST   = 8'(SETUP);
    localparam logic [7:0] ACK_LAST     = 8'(ACK_WIDTH - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_ACK_HI,
        ST_WAIT_REL
    } state_t;

    logic [2:0]  req_in;
    logic [2:0]  req_s1_reg;
    logic [2:0]  req_s2_reg;
    logic [2:0]  req_s3_reg;
    logic [2:0]  req_rise;

    logic [2:0]  nss_sync_reg;
    logic [2:0]  sck_sync_reg;
    logic [1:0]  mosi_sync_reg;
    logic        nss_fall;
    logic        nss_rise;
    logic        sck_rise;
    logic        sck_fall;

    logic [4:0]  bit_cnt_reg;
    logic [15:0] shift_in_reg;
    logic [15:0] shift_out_reg;
    logic        miso_reg;
    logic [3:0]  spi_idx;
    logic [7:0]  spi_data;
    logic        commit;
    logic        commit_write;
    logic        commit_clr;
    logic        unused_reserved;

    logic [7:0]      reg_q       [NREG];
    logic [7:0]      reg_rst_val [NREG];
    logic [NREG-1:0] reg_we;

    state_t      state_reg;
    logic [7:0]  cnt_reg;
    logic [1:0]  type_reg;
    logic [7:0]  dout_reg;
    logic        doe_reg;
    logic        ack_reg;
    logic        err_reg;
    logic [6:0]  req_count_reg;
    logic [7:0]  potgo_reg;

    assign req_in = {REQ_BTN, REQ_JOY, REQ_RTC};

    // REQ synchronisers carry no reset so a line held high across RESET
    // does not look like a fresh rising edge afterwards.
    always_ff @(posedge CLKCPU_A) begin
        req_s1_reg <= req_in;
        req_s2_reg <= req_s1_reg;
        req_s3_reg <= req_s2_reg;
    end

    assign req_rise = req_s2_reg & ~req_s3_reg;

    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            nss_sync_reg  <= 3'b111;
            sck_sync_reg  <= 3'b000;
            mosi_sync_reg <= 2'b00;
        end else begin
            nss_sync_reg  <= {nss_sync_reg[1:0], SPI_NSS};
            sck_sync_reg  <= {sck_sync_reg[1:0], SPI_CK};
            mosi_sync_reg <= {mosi_sync_reg[0], SPI_MOSI};
        end
    end

    assign nss_fall = nss_sync_reg[2] & ~nss_sync_reg[1];
    assign nss_rise = ~nss_sync_reg[2] & nss_sync_reg[1];
    assign sck_rise = ~sck_sync_reg[2] & sck_sync_reg[1];
    assign sck_fall = sck_sync_reg[2] & ~sck_sync_reg[1];

    assign spi_idx         = shift_in_reg[11:8];
    assign spi_data        = shift_in_reg[7:0];
    assign commit          = nss_rise & (bit_cnt_reg == 5'd16);
    assign commit_write    = commit & shift_in_reg[15] & (spi_idx <= 4'd11);
    assign commit_clr      = commit & shift_in_reg[14];
    assign unused_reserved = ^shift_in_reg[13:12];

    // Bit counter saturates so that long frames can never alias back to 16.
    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            bit_cnt_reg   <= 5'd0;
            shift_in_reg  <= 16'h0000;
            shift_out_reg <= 16'h0000;
            miso_reg      <= 1'b0;
        end else if (nss_fall) begin
            bit_cnt_reg   <= 5'd0;
            shift_out_reg <= {potgo_reg, err_reg, req_count_reg};
            miso_reg      <= potgo_reg[7];
        end else if (!nss_sync_reg[1]) begin
            if (sck_rise) begin
                shift_in_reg <= {shift_in_reg[14:0], mosi_sync_reg[1]};
                if (bit_cnt_reg != 5'd31) begin
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                end
            end
            if (sck_fall) begin
                shift_out_reg <= {shift_out_reg[14:0], 1'b0};
                miso_reg      <= shift_out_reg[14];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            assign reg_we[gi]      = commit_write & (spi_idx == 4'(gi));
            assign reg_rst_val[gi] = (gi >= 8) ? 8'hFF : 8'h00;
        end
    endgenerate

    always_ff @(posedge CLKCPU_A) begin
        for (int i = 0; i < NREG; i++) begin
            if (RESET) begin
                reg_q[i] <= reg_rst_val[i];
            end else if (reg_we[i]) begin
                reg_q[i] <= spi_data;
            end
        end
    end

    always_ff @(posedge CLKCPU_A) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            type_reg      <= TYPE_RTC;
            dout_reg      <= 8'h00;
            doe_reg       <= 1'b0;
            ack_reg       <= 1'b0;
            err_reg       <= 1'b0;
            req_count_reg <= 7'd0;
            potgo_reg     <= 8'h00;
        end else begin
            if (commit_clr) begin
                err_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (|req_rise) begin
                        state_reg <= ST_SERVE;
                        cnt_reg   <= 8'd0;
                        if (req_rise[0]) begin
                            type_reg <= TYPE_RTC;
                        end else if (req_rise[1]) begin
                            type_reg <= TYPE_JOY;
                        end else begin
                            type_reg <= TYPE_BTN;
                        end
                    end
                end
                ST_SERVE: begin
                    // The read sees the register value from before any same-cycle SPI commit.
                    if (cnt_reg == 8'd0) begin
                        if (RW) begin
                            dout_reg <= reg_q[{type_reg, SEL}];
                            doe_reg  <= 1'b1;
                        end else if (type_reg == TYPE_BTN) begin
                            potgo_reg <= D_IN;
                        end
                        req_count_reg <= req_count_reg + 7'd1;
                    end
                    if (cnt_reg == SETUP_LAST) begin
                        state_reg <= ST_ACK_HI;
                        ack_reg   <= 1'b1;
                        cnt_reg   <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_ACK_HI: begin
                    if (cnt_reg == ACK_LAST) begin
                        state_reg <= ST_WAIT_REL;
                        ack_reg   <= 1'b0;
                        cnt_reg   <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_WAIT_REL: begin
                    if (!req_s3_reg[type_reg]) begin
                        state_reg <= ST_IDLE;
                        doe_reg   <= 1'b0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= ST_IDLE;
                        doe_reg   <= 1'b0;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign D_OUT    = dout_reg;
    assign D_OE     = doe_reg;
    assign ACK      = ack_reg;
    assign SPI_MISO = miso_reg;

endmodule

// File: tb/tb_punt_responder.sv
// Self-checking bench for punt_responder: timestamp-based reference model plus
// directed scenarios with literal expectations.
module tb_punt_responder;

    localparam int SETUP     = 2;
    localparam int ACK_WIDTH = 4;
    localparam int TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_rtc, req_btn, req_joy;
    logic [1:0] sel;
    logic       rw;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe, ack;
    logic       spi_nss, spi_ck, spi_mosi, spi_miso;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    punt_responder #(.SETUP(SETUP), .ACK_WIDTH(ACK_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLKCPU_A (clk),
        .RESET    (rst),
        .REQ_RTC  (req_rtc),
        .REQ_BTN  (req_btn),
        .REQ_JOY  (req_joy),
        .SEL      (sel),
        .RW       (rw),
        .D_IN     (d_in),
        .D_OUT    (d_out),
        .D_OE     (d_oe),
        .ACK      (ack),
        .SPI_NSS  (spi_nss),
        .SPI_CK   (spi_ck),
        .SPI_MOSI (spi_mosi),
        .SPI_MISO (spi_miso)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request is a timeline relative to the
    // edge n at which the request line was first sampled high.
    logic [7:0] m_regs [12];
    logic [7:0] m_potgo;
    logic       m_err;
    logic [6:0] m_count;
    bit         m_busy;
    int         m_start;
    int         m_type;
    int         m_t;
    int         cyc = 0;
    bit [3:0]   m_hist [3];
    logic [7:0] e_dout = 8'h00;
    logic       e_doe = 1'b0;
    logic       e_ack = 1'b0;
    bit         chk_en = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 12; i++) m_regs[i] = (i >= 8) ? 8'hFF : 8'h00;
        m_potgo = 8'h00;
        m_err   = 1'b0;
        m_count = 7'd0;
        m_busy  = 1'b0;
        e_dout  = 8'h00;
        e_doe   = 1'b0;
        e_ack   = 1'b0;
    endtask

    always @(posedge clk) begin
        cyc++;
        m_hist[0] = {m_hist[0][2:0], req_rtc};
        m_hist[1] = {m_hist[1][2:0], req_joy};
        m_hist[2] = {m_hist[2][2:0], req_btn};
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
                if (!m_busy && m_hist[k][2] && !m_hist[k][3]) begin
                    m_busy  = 1'b1;
                    m_start = cyc - 2;
                    m_type  = k;
                end
            end
        end else begin
            m_t = cyc - m_start;
            if (m_t == 3) begin
                if (rw) begin
                    e_dout = m_regs[m_type * 4 + int'(sel)];
                    e_doe  = 1'b1;
                end else if (m_type == 2) begin
                    m_potgo = d_in;
                end
                m_count = m_count + 7'd1;
            end
            if (m_t == 3 + SETUP) e_ack = 1'b1;
            if (m_t == 3 + SETUP + ACK_WIDTH) e_ack = 1'b0;
            if (m_t > 3 + SETUP + ACK_WIDTH) begin
                if (!m_hist[m_type][3]) begin
                    e_doe  = 1'b0;
                    m_busy = 1'b0;
                end else if (m_t == 3 + SETUP + ACK_WIDTH + TIMEOUT) begin
                    e_doe  = 1'b0;
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("d_oe", 32'(d_oe), 32'(e_doe));
            check("d_out", 32'(d_out), 32'(e_dout));
        end
    end

    // Sends nbits of word (MSB first) and returns the first 16 MISO bits.
    task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [15:0] got);
        logic [15:0] exp_miso;
        exp_miso = {m_potgo, m_err, m_count};
        got = 16'h0000;
        @(negedge clk);
        spi_nss = 1'b0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            spi_mosi = word[nbits - 1 - b];
            repeat (4) @(negedge clk);
            if (b < 16) got = {got[14:0], spi_miso};
            spi_ck = 1'b1;
            repeat (4) @(negedge clk);
            spi_ck = 1'b0;
        end
        repeat (5) @(negedge clk);
        spi_nss = 1'b1;
        repeat (6) @(negedge clk);
        if (nbits >= 16) check("miso_word", 32'(got), 32'(exp_miso));
        if (nbits == 16) begin
            if (word[15] && word[11:8] <= 4'd11) m_regs[word[11:8]] = word[7:0];
            if (word[14]) m_err = 1'b0;
        end
        $display("spi frame bits=%0d word=0x%0h miso=0x%04h", nbits, word, got);
    endtask

    task automatic pulse(input logic [2:0] mask, input int hold, output int ack_cyc, output int doe_cyc);
        ack_cyc = 0;
        doe_cyc = 0;
        @(negedge clk);
        {req_btn, req_joy, req_rtc} = mask;
        for (int i = 0; i < hold + 12; i++) begin
            @(negedge clk);
            if (i == hold) {req_btn, req_joy, req_rtc} = 3'b000;
            ack_cyc += int'(ack);
            doe_cyc += int'(d_oe);
        end
        $display("request mask=%03b sel=%0d rw=%0d: ack_cycles=%0d doe_cycles=%0d d_out=0x%02h",
                 mask, sel, rw, ack_cyc, doe_cyc, d_out);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] w;
    int          ack_cyc, doe_cyc, ack_cnt;

    initial begin
        rst = 1'b1;
        {req_rtc, req_btn, req_joy} = 3'b000;
        sel = 2'b00; rw = 1'b1; d_in = 8'h00;
        spi_nss = 1'b1; spi_ck = 1'b0; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        check("rst_d_out", 32'(d_out), 32'h00);
        check("rst_d_oe", 32'(d_oe), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_miso", 32'(spi_miso), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Read path with exact cycle positions relative to edge n
        spi_frame(32'h855A, 16, w);
        check("miso_after_rst", 32'(w), 32'h0000);
        @(negedge clk);
        sel = 2'b01; rw = 1'b1; req_joy = 1'b1;
        for (int t = 0; t <= 14; t++) begin
            @(posedge clk);
            #1;
            if (t == 2) check("rd_doe_n2", 32'(d_oe), 32'h0);
            if (t == 3) begin
                check("rd_doe_n3", 32'(d_oe), 32'h1);
                check("rd_dout_n3", 32'(d_out), 32'h5A);
            end
            if (t == 4) check("rd_ack_n4", 32'(ack), 32'h0);
            if (t == 5) check("rd_ack_n5", 32'(ack), 32'h1);
            if (t == 8) check("rd_ack_n8", 32'(ack), 32'h1);
            if (t == 9) begin
                check("rd_ack_n9", 32'(ack), 32'h0);
                @(negedge clk);
                req_joy = 1'b0;
            end
            if (t == 12) check("rd_doe_rel2", 32'(d_oe), 32'h1);
            if (t == 13) check("rd_doe_rel3", 32'(d_oe), 32'h0);
        end
        $display("read path done: d_out=0x%02h", d_out);
        repeat (6) @(negedge clk);

        // Write path after a fresh reset
        do_reset(3);
        repeat (4) @(negedge clk);
        sel = 2'b00; rw = 1'b0; d_in = 8'hC3;
        pulse(3'b100, 12, ack_cyc, doe_cyc);
        check("wr_ack_cycles", 32'(ack_cyc), 32'd4);
        check("wr_doe_cycles", 32'(doe_cyc), 32'd0);
        spi_frame(32'h0000, 16, w);
        check("wr_miso", 32'(w), 32'hC301);

        // Simultaneous RTC and BTN edges: RTC wins
        spi_frame(32'h8011, 16, w);
        spi_frame(32'h8822, 16, w);
        sel = 2'b00; rw = 1'b1;
        pulse(3'b101, 12, ack_cyc, doe_cyc);
        check("pri_dout", 32'(d_out), 32'h11);
        check("pri_ack_cycles", 32'(ack_cyc), 32'd4);
        spi_frame(32'h0000, 16, w);
        check("pri_miso", 32'(w), 32'hC302);

        // Request held past the timeout
        @(negedge clk);
        sel = 2'b10; rw = 1'b1; req_rtc = 1'b1;
        for (int t = 0; t <= 275; t++) begin
            @(posedge clk);
            #1;
            if (t == 263) check("to_doe_263", 32'(d_oe), 32'h1);
            if (t == 264) check("to_doe_264", 32'(d_oe), 32'h0);
            if (t == 270) begin
                @(negedge clk);
                req_rtc = 1'b0;
            end
        end
        $display("timeout request done: d_oe=%0d", d_oe);
        spi_frame(32'h0000, 16, w);
        check("to_err_set", 32'(w), 32'hC383);
        spi_frame(32'h4000, 16, w);
        spi_frame(32'h0000, 16, w);
        check("to_err_clr", 32'(w), 32'hC303);

        // Short and long frames, and an out-of-range index, change nothing
        spi_frame(32'h843C, 16, w);
        spi_frame(32'h4277, 15, w);
        spi_frame(32'h109DC, 17, w);
        spi_frame(32'h8CAB, 16, w);
        sel = 2'b00; rw = 1'b1;
        pulse(3'b010, 12, ack_cyc, doe_cyc);
        check("bad_frame_dout", 32'(d_out), 32'h3C);
        check("rd_doe_cycles", 32'(doe_cyc), 32'd13);
        sel = 2'b11;
        pulse(3'b100, 12, ack_cyc, doe_cyc);
        check("btn_rst_val", 32'(d_out), 32'hFF);

        // RESET during ACK_HI; request stays high afterwards
        @(negedge clk);
        sel = 2'b01; rw = 1'b1; req_joy = 1'b1;
        ack_cnt = 0;
        for (int t = 0; t <= 30; t++) begin
            @(posedge clk);
            #1;
            if (t == 5) check("rst_mid_ack_hi", 32'(ack), 32'h1);
            if (t == 6) begin
                @(negedge clk);
                rst = 1'b1;
            end
            if (t == 7) begin
                check("rst_mid_ack", 32'(ack), 32'h0);
                check("rst_mid_doe", 32'(d_oe), 32'h0);
                check("rst_mid_dout", 32'(d_out), 32'h00);
                check("rst_mid_miso", 32'(spi_miso), 32'h0);
                @(negedge clk);
                rst = 1'b0;
            end
            if (t > 7 && ack) ack_cnt++;
        end
        check("rst_no_ack", 32'(ack_cnt), 32'd0);
        $display("reset during ack: ack cycles after reset=%0d", ack_cnt);
        @(negedge clk);
        req_joy = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
